hilo_wb_unit: RTL and testbench

Writeback result stage for the pipelined CPU: a parametrised, registered successor to the combinational writeback select. It owns the HI/LO register pair and an iterative unsigned multiplier. It decodes the R-type funct field to choose among ALU, shifter, HI and LO results, and adds MTHI/MTLO support. It stalls the upstream stage while a HI/LO-dependent instruction would race an in-flight multiply.

---
 rtl/hilo_pkg.sv | 49 ++++
 rtl/hilo_wb_unit_multu.sv | 92 +++++++++
 rtl/hilo_wb_unit.sv | 96 +++++++++
 tb/tb_hilo_wb_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO writeback unit.
//   - funct codes of the R-type instructions the unit understands
//   - wb_op_e: decoded operation class
//   - is_hilo_op(): funct codes that must not race an in-flight multiply
//                   (also used by the hazard unit)
package hilo_pkg;

   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MTLO  = 6'b010011;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_ALU,
      OP_SHIFT,
      OP_MFHI,
      OP_MFLO,
      OP_MTHI,
      OP_MTLO,
      OP_MULTU
   } wb_op_e;

   function automatic logic is_hilo_op(input logic [5:0] funct);
      return (funct == FN_MULTU) || (funct == FN_MFHI) || (funct == FN_MFLO) ||
             (funct == FN_MTHI)  || (funct == FN_MTLO);
   endfunction

   function automatic wb_op_e decode_funct(input logic [5:0] funct);
      case (funct)
         FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: return OP_ALU;
         FN_SRL:   return OP_SHIFT;
         FN_MFHI:  return OP_MFHI;
         FN_MFLO:  return OP_MFLO;
         FN_MTHI:  return OP_MTHI;
         FN_MTLO:  return OP_MTLO;
         FN_MULTU: return OP_MULTU;
         default:  return OP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/hilo_wb_unit_multu.sv
// multu_iter: iterative unsigned shift-add multiplier, one multiplier bit
// per cycle, WIDTH cycles per product.
//   clk, rst_n : clock, async active-low reset
//   start      : load a/b and begin (ignored while busy)
//   a, b       : multiplicand, multiplier
//   busy       : multiply in flight (registered)
//   done       : combinational, high during the last iteration cycle;
//                hi/lo carry the finished product in that cycle
//   hi, lo     : upper/lower halves of the product (valid with done)
//
// state   | meaning
// ST_IDLE | no multiply in flight, waiting for start
// ST_RUN  | one shift-add iteration per cycle, cnt_q counts down to 0
module multu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {ST_IDLE, ST_RUN} mul_state_e;

   mul_state_e           state_q, state_nxt;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   acc_nxt;
   logic                 tc;

   assign tc      = (cnt_q == '0);
   assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_nxt = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (tc) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (state_q == ST_IDLE) begin
         if (start) begin
            cnt_q    <= CW'(WIDTH - 1);
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
         end
      end else begin
         cnt_q    <= tc ? '0 : cnt_q - 1'b1;
         acc_q    <= acc_nxt;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end

   // The final partial sum is forwarded so HI/LO load on the same edge busy falls.
   assign hi = acc_nxt[2*WIDTH-1:WIDTH];
   assign lo = acc_nxt[WIDTH-1:0];

endmodule

// File: rtl/hilo_wb_unit.sv
// hilo_wb_unit: registered writeback select with HI/LO registers and an
// iterative unsigned multiplier.
//   clk, rst_n          : clock, async active-low reset
//   in_valid, funct     : instruction presented / R-type funct
//   alu_out, shift_out  : candidate writeback results
//   rs_val, rt_val      : multiply operands, MTHI/MTLO source (rs)
//   stall               : instruction not accepted, upstream holds
//   out_valid, data_out : registered writeback result
//   busy                : multiply in flight
module hilo_wb_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [WIDTH-1:0] shift_out,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] data_out,
   output logic             busy
);

   wb_op_e           op;
   logic             accept;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             wb_valid;
   logic [WIDTH-1:0] wb_data;

   assign op        = decode_funct(funct);
   // Only registered busy feeds stall, so no path from out_valid back to stall.
   assign stall     = in_valid & mul_busy & is_hilo_op(funct);
   assign accept    = in_valid & ~stall;
   assign mul_start = accept & (op == OP_MULTU);
   assign busy      = mul_busy;

   multu_iter #(.WIDTH(WIDTH)) u_multu (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .a     (rs_val),
      .b     (rt_val),
      .busy  (mul_busy),
      .done  (mul_done),
      .hi    (mul_hi),
      .lo    (mul_lo)
   );

   always_comb begin
      wb_valid = 1'b0;
      wb_data  = '0;
      case (op)
         OP_ALU:   begin wb_valid = 1'b1; wb_data = alu_out;   end
         OP_SHIFT: begin wb_valid = 1'b1; wb_data = shift_out; end
         OP_MFHI:  begin wb_valid = 1'b1; wb_data = hi_q;      end
         OP_MFLO:  begin wb_valid = 1'b1; wb_data = lo_q;      end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         data_out  <= '0;
      end else begin
         out_valid <= accept & wb_valid;
         if (accept & wb_valid) data_out <= wb_data;
      end
   end

   // MTHI/MTLO stall while busy, so they can never collide with mul_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (mul_done) begin
         hi_q <= mul_hi;
         lo_q <= mul_lo;
      end else if (accept) begin
         if (op == OP_MTHI) hi_q <= rs_val;
         if (op == OP_MTLO) lo_q <= rs_val;
      end
   end

endmodule

// File: tb/tb_hilo_wb_unit.sv
module tb_hilo_wb_unit;

   localparam int W = 32;
   localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_ADD = 6'b100000,
                          F_SUB = 6'b100010, F_SLT = 6'b101010, F_SRL = 6'b000010,
                          F_MULTU = 6'b011001, F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                          F_MTHI = 6'b010001, F_MTLO = 6'b010011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0;
   logic [5:0]    funct = '0;
   logic [W-1:0]  alu_out = '0, shift_out = '0, rs_val = '0, rt_val = '0;
   logic          stall, out_valid, busy;
   logic [W-1:0]  data_out;

   hilo_wb_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .funct(funct),
      .alu_out(alu_out), .shift_out(shift_out), .rs_val(rs_val), .rt_val(rt_val),
      .stall(stall), .out_valid(out_valid), .data_out(data_out), .busy(busy)
   );

   logic          in_valid8 = 1'b0;
   logic [5:0]    funct8 = '0;
   logic [7:0]    alu8 = '0, sh8 = '0, rs8 = '0, rt8 = '0;
   logic          stall8, out_valid8, busy8;
   logic [7:0]    data8;

   hilo_wb_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .funct(funct8),
      .alu_out(alu8), .shift_out(sh8), .rs_val(rs8), .rt_val(rt8),
      .stall(stall8), .out_valid(out_valid8), .data_out(data8), .busy(busy8)
   );

   int n_cmp = 0;
   int n_err = 0;
   int edge_n = 0;
   always @(posedge clk) edge_n++;

   // reference model state
   logic [W-1:0] exp_q[$];
   logic [7:0]   exp8_q[$];
   logic [W-1:0] hi_m = '0, lo_m = '0, last_m = '0;
   logic [7:0]   hi8_m = '0, lo8_m = '0;
   int mult_e0 = -1, mult_end = -1, mult8_end = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic hilo_class(input logic [5:0] f);
      return f == F_MULTU || f == F_MFHI || f == F_MFLO || f == F_MTHI || f == F_MTLO;
   endfunction

   // scoreboard monitor, 32-bit instance
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               check("data_out", data_out, e);
               last_m = e;
            end
         end else begin
            check("data_hold", data_out, last_m);
         end
         check("busy", busy, (mult_e0 >= 0) && (edge_n >= mult_e0) && (edge_n < mult_end));
         if (!in_valid) check("stall_idle", stall, 0);
      end
   end

   // scoreboard monitor, 8-bit instance
   always @(negedge clk) begin
      if (rst_n && out_valid8) begin
         if (exp8_q.size() == 0) check("unexpected_out_valid8", 1, 0);
         else check("data_out8", data8, exp8_q.pop_front());
      end
   end

   // model update on the accepting edge
   task automatic apply(input logic [5:0] f, input logic [W-1:0] alu, sh, rs, rt, input int acc_edge);
      logic [63:0] p;
      case (f)
         F_AND, F_OR, F_ADD, F_SUB, F_SLT: exp_q.push_back(alu);
         F_SRL:  exp_q.push_back(sh);
         F_MFHI: exp_q.push_back(hi_m);
         F_MFLO: exp_q.push_back(lo_m);
         F_MTHI: hi_m = rs;
         F_MTLO: lo_m = rs;
         F_MULTU: begin
            p = 64'(rs) * 64'(rt);
            hi_m = p[63:32];
            lo_m = p[31:0];
            mult_e0 = acc_edge;
            mult_end = acc_edge + W;
         end
         default: ;
      endcase
   endtask

   task automatic issue(input logic [5:0] f, input logic [W-1:0] alu, sh, rs, rt);
      int present, exp_acc, stalls, acc_edge;
      in_valid = 1'b1; funct = f; alu_out = alu; shift_out = sh; rs_val = rs; rt_val = rt;
      @(negedge clk);
      present = edge_n + 1;
      exp_acc = present;
      if (hilo_class(f) && mult_end >= present) exp_acc = mult_end + 1;
      stalls = 0;
      while (stall === 1'b1 && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 200) $display("FAIL stall_timeout: got %0d cycles expected %0d", stalls, exp_acc - present);
      check($sformatf("stall_cycles_f%02h", f), stalls, exp_acc - present);
      acc_edge = edge_n + 1;
      @(posedge clk);
      apply(f, alu, sh, rs, rt, acc_edge);
      #1 in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue8(input logic [5:0] f, input logic [7:0] rs, rt);
      int present, exp_acc, stalls, acc_edge;
      logic [15:0] p;
      in_valid8 = 1'b1; funct8 = f; rs8 = rs; rt8 = rt;
      @(negedge clk);
      present = edge_n + 1;
      exp_acc = (hilo_class(f) && mult8_end >= present) ? mult8_end + 1 : present;
      stalls = 0;
      while (stall8 === 1'b1 && stalls < 50) begin
         stalls++;
         @(negedge clk);
      end
      check("stall_cycles8", stalls, exp_acc - present);
      acc_edge = edge_n + 1;
      @(posedge clk);
      case (f)
         F_MULTU: begin
            p = 16'(rs) * 16'(rt);
            hi8_m = p[15:8]; lo8_m = p[7:0];
            mult8_end = acc_edge + 8;
         end
         F_MFHI: exp8_q.push_back(hi8_m);
         F_MFLO: exp8_q.push_back(lo8_m);
         default: ;
      endcase
      #1 in_valid8 = 1'b0;
   endtask

   logic [5:0] fl[13] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MULTU,
                          F_MFHI, F_MFLO, F_MTHI, F_MTLO, 6'b000000, 6'b111111};

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_busy", busy, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // directed
      issue(F_ADD, 32'h1234_5678, 0, 0, 0);
      issue(F_SRL, 0, 32'h0000_00F0, 0, 0);
      issue(F_MULTU, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(F_MFHI, 0, 0, 0, 0);
      issue(F_MFLO, 0, 0, 0, 0);
      issue(F_MULTU, 0, 0, 32'h0001_0003, 32'h0000_0007);
      for (int i = 0; i < 5; i++) issue(F_ADD, 32'hA000_0000 + i, 0, 0, 0);
      issue(F_MFLO, 0, 0, 0, 0);
      issue(F_MULTU, 0, 0, 32'h8000_0001, 32'h0000_0002);
      issue(F_MULTU, 0, 0, 32'h0000_0005, 32'h0000_0006);
      issue(F_MFHI, 0, 0, 0, 0);

      // reset in the middle of a multiply
      issue(F_MULTU, 0, 0, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midmul_rst_busy", busy, 0);
      check("midmul_rst_out_valid", out_valid, 0);
      check("midmul_rst_data", data_out, 0);
      check("midmul_queue_empty", exp_q.size(), 0);
      exp_q.delete();
      hi_m = '0; lo_m = '0; last_m = '0; mult_e0 = -1; mult_end = -1;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(F_MFHI, 0, 0, 0, 0);
      issue(F_MTLO, 0, 0, 32'hA5A5_A5A5, 0);
      issue(F_MFLO, 0, 0, 0, 0);
      issue(F_MFHI, 0, 0, 0, 0);

      // randomized
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         issue(fl[$urandom_range(0, 12)], $urandom, $urandom, $urandom, $urandom);
      end
      idle(W + 2);
      issue(F_MFHI, 0, 0, 0, 0);
      issue(F_MFLO, 0, 0, 0, 0);

      // narrow instance
      issue8(F_MULTU, 8'd200, 8'd200);
      issue8(F_MFHI, 0, 0);
      issue8(F_MFLO, 0, 0);
      issue8(F_MULTU, 8'hFF, 8'h81);
      issue8(F_MFLO, 0, 0);
      issue8(F_MFHI, 0, 0);

      idle(4);
      check("queue_drained", exp_q.size(), 0);
      check("queue8_drained", exp8_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end of test expected completion");
      $fatal(1, "timeout");
   end

endmodule
